// File: rtl/stage_sequencer.sv
// stage_sequencer: sweeps one frame from the input ping-pong buffer through a
// processing core into the output ping-pong buffer. It tracks both bank
// selects, generates the read and write strobes and addresses, and pulses
// stage_done for one cycle after the last result word has been written.
module stage_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_LEN  = 1024,
  parameter bit INIT_BANK  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stage_ready,
  input  logic                  buf_switch_in,
  input  logic                  buf_switch_out,
  input  logic                  core_ready,
  input  logic                  core_valid,
  output logic                  rd_bank,
  output logic                  wr_bank,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  stage_done,
  output logic                  protocol_err
);

  // One extra bit lets a full 2^ADDR_WIDTH frame finish while the address wraps.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            rd_bank_q, rd_bank_d;
  logic            wr_bank_q, wr_bank_d;
  logic            err_q, err_d;
  logic            active;
  logic            pending;

  // Next-state, counter, bank and error logic plus the combinational strobes.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_bank_d  = rd_bank_q ^ buf_switch_in;
    wr_bank_d  = wr_bank_q ^ buf_switch_out;
    active     = (state_q == READ) || (state_q == DRAIN);
    busy       = (state_q != IDLE);
    stage_done = (state_q == DONE);
    // A result word is only legal once its read has been issued.
    pending    = (wr_cnt_q < rd_cnt_q);
    rd_en      = 1'b0;
    wr_en      = active && core_valid && pending;
    err_d      = err_q
               | (busy && (stage_ready || buf_switch_in || buf_switch_out))
               | (core_valid && !(active && pending));

    if (wr_en) wr_cnt_d = wr_cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (stage_ready) begin
          state_d  = READ;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      READ: begin
        rd_en = core_ready;
        if (rd_en) rd_cnt_d = rd_cnt_q + CW'(1);
        if (wr_en && (wr_cnt_q == LAST))      state_d = DONE;
        else if (rd_en && (rd_cnt_q == LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_en && (wr_cnt_q == LAST)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, banks and sticky error flag; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rd_bank_q <= INIT_BANK;
      wr_bank_q <= INIT_BANK;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      err_q     <= err_d;
    end
  end

  assign rd_addr      = rd_cnt_q[ADDR_WIDTH-1:0];
  assign wr_addr      = wr_cnt_q[ADDR_WIDTH-1:0];
  assign rd_bank      = rd_bank_q;
  assign wr_bank      = wr_bank_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer with an 8-word frame and 3-bit addresses, using a
// frame-level reference model (word counts, banks, sticky error).
module tb_stage_sequencer;

  localparam int AW = 3;
  localparam int FL = 8;
  localparam int VW = 2 * AW + 7;
  localparam logic [VW-1:0] RST_VEC = '0;

  logic clk = 1'b0;
  logic rst_n, stage_ready, buf_switch_in, buf_switch_out, core_ready, core_valid;
  logic rd_bank, wr_bank, rd_en, wr_en, busy, stage_done, protocol_err;
  logic [AW-1:0] rd_addr, wr_addr;

  int vectors = 0;
  int miscompares = 0;
  logic d1 = 1'b0, d2 = 1'b0;

  stage_sequencer #(.ADDR_WIDTH(AW), .FRAME_LEN(FL), .INIT_BANK(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .stage_ready(stage_ready),
    .buf_switch_in(buf_switch_in), .buf_switch_out(buf_switch_out),
    .core_ready(core_ready), .core_valid(core_valid),
    .rd_bank(rd_bank), .wr_bank(wr_bank), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .stage_done(stage_done),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Reference model: frame in flight, words read/written, done cycle, banks, error.
  bit m_active, m_done, m_rb, m_wb, m_err;
  int m_reads, m_writes;
  logic e_busy, e_rd, e_wr;
  logic [VW-1:0] exp_vec, act_vec;

  assign act_vec = {rd_bank, wr_bank, rd_en, rd_addr, wr_en, wr_addr, busy, stage_done, protocol_err};

  always_comb begin
    e_busy  = m_active || m_done;
    e_rd    = m_active && (m_reads < FL) && core_ready;
    e_wr    = m_active && core_valid && (m_writes < m_reads);
    exp_vec = {m_rb, m_wb, e_rd, AW'(m_reads % (1 << AW)), e_wr,
               AW'(m_writes % (1 << AW)), e_busy, m_done, m_err};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_rb <= 1'b0; m_wb <= 1'b0; m_err <= 1'b0;
      m_reads <= 0; m_writes <= 0;
    end else begin
      if (buf_switch_in)  m_rb <= !m_rb;
      if (buf_switch_out) m_wb <= !m_wb;
      if ((e_busy && (stage_ready || buf_switch_in || buf_switch_out)) ||
          (core_valid && !(m_active && (m_writes < m_reads))))
        m_err <= 1'b1;
      if (m_done) m_done <= 1'b0;
      else if (m_active) begin
        m_reads  <= m_reads + int'(e_rd);
        m_writes <= m_writes + int'(e_wr);
        if (m_writes + int'(e_wr) == FL) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end else if (stage_ready) begin
        m_active <= 1'b1; m_reads <= 0; m_writes <= 0;
      end
    end
  end

  task automatic idle_inputs();
    stage_ready = 1'b0; buf_switch_in = 1'b0; buf_switch_out = 1'b0;
    core_ready = 1'b1; core_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    vectors++;
    if (act_vec !== RST_VEC) begin
      miscompares++;
      $display("FAIL reset_state got=%b want=%b", act_vec, RST_VEC);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d got=%b want=%b", k, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_basic_frame();
    int nrd = 0, first_rd = -1, last_wr = -1, done_k = -1, ndone = 0;
    d1 = 1'b0; d2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      stage_ready = (k == 0);
      core_valid  = d2;
      @(negedge clk);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL basic k=%0d got=%b want=%b", k, act_vec, exp_vec);
      end
      if (rd_en) begin nrd++; if (first_rd < 0) first_rd = k; end
      if (wr_en) last_wr = k;
      if (stage_done) begin ndone++; done_k = k; end
      d2 = d1; d1 = rd_en;
    end
    vectors++;
    if (nrd != 8 || first_rd != 1 || last_wr != 10 || done_k != 11 || ndone != 1 || protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_timing got reads=%0d first=%0d lastwr=%0d done=%0d ndone=%0d err=%b want 8/1/10/11/1/0",
               nrd, first_rd, last_wr, done_k, ndone, protocol_err);
    end
  endtask

  task automatic test_ready_toggle();
    int nrd = 0, bad_addr = 0, last_wr = -1, done_k = -1;
    d1 = 1'b0; d2 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      stage_ready = (k == 0);
      core_ready  = (k % 2 == 1);
      core_valid  = d2;
      @(negedge clk);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL toggle k=%0d got=%b want=%b", k, act_vec, exp_vec);
      end
      if (rd_en) begin
        if (int'(rd_addr) != nrd % FL) bad_addr++;
        nrd++;
      end
      if (wr_en) last_wr = k;
      if (stage_done) done_k = k;
      d2 = d1; d1 = rd_en;
    end
    vectors++;
    if (nrd != 8 || bad_addr != 0 || done_k != last_wr + 1 || done_k < 0) begin
      miscompares++;
      $display("FAIL toggle_counts got reads=%0d badaddr=%0d lastwr=%0d done=%0d want 8/0/done=lastwr+1",
               nrd, bad_addr, last_wr, done_k);
    end
  endtask

  task automatic test_banks();
    int bad1 = 0, bad0 = 0, nbusy = 0;
    d1 = 1'b0; d2 = 1'b0;
    for (int k = 0; k < 34; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      buf_switch_in  = (k == 0) || (k == 16);
      buf_switch_out = (k == 0) || (k == 16);
      stage_ready    = (k == 1) || (k == 16);
      core_valid     = d2;
      @(negedge clk);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL banks k=%0d got=%b want=%b", k, act_vec, exp_vec);
      end
      if (busy) begin
        nbusy++;
        if (k < 16 && !(rd_bank === 1'b1 && wr_bank === 1'b1)) bad1++;
        if (k > 16 && !(rd_bank === 1'b0 && wr_bank === 1'b0)) bad0++;
      end
      d2 = d1; d1 = rd_en;
    end
    vectors++;
    if (bad1 != 0 || bad0 != 0 || nbusy != 22 || protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bank_select got bad1=%0d bad0=%0d busy=%0d err=%b want 0/0/22/0",
               bad1, bad0, nbusy, protocol_err);
    end
  endtask

  task automatic test_protocol();
    int nwr = 0, done_k = -1, ndone = 0;
    d1 = 1'b0; d2 = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      stage_ready = (k == 2) || (k == 6);
      core_valid  = d2 | (k == 0);
      @(negedge clk);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL protocol k=%0d got=%b want=%b", k, act_vec, exp_vec);
      end
      if (k >= 1 && protocol_err !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL sticky_err k=%0d got=%b want=1", k, protocol_err);
      end
      if (wr_en) nwr++;
      if (stage_done) begin ndone++; done_k = k; end
      d2 = d1; d1 = rd_en;
    end
    vectors++;
    if (nwr != 8 || done_k != 13 || ndone != 1) begin
      miscompares++;
      $display("FAIL protocol_frame got writes=%0d done=%0d ndone=%0d want 8/13/1", nwr, done_k, ndone);
    end
  endtask

  task automatic test_midreset();
    int ndone = 0, first_addr = -1;
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d1 = 1'b0; d2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      stage_ready = (k == 0);
      core_valid  = d2;
      if (k == 5) begin
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (act_vec !== RST_VEC) begin
          miscompares++;
          $display("FAIL async_reset got=%b want=%b", act_vec, RST_VEC);
        end
      end
      @(negedge clk);
      d2 = d1; d1 = rd_en;
    end
    @(posedge clk); #1;
    d1 = 1'b0; d2 = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      stage_ready = (k == 4);
      core_valid  = d2;
      @(negedge clk);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL midreset k=%0d got=%b want=%b", k, act_vec, exp_vec);
      end
      if (stage_done && k < 5) ndone++;
      if (rd_en && first_addr < 0) first_addr = int'(rd_addr);
      d2 = d1; d1 = rd_en;
    end
    vectors++;
    if (ndone != 0 || first_addr != 0 || protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_restart got early_done=%0d first_addr=%0d err=%b want 0/0/0",
               ndone, first_addr, protocol_err);
    end
  endtask

  task automatic test_random();
    d1 = 1'b0; d2 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      stage_ready    = ($urandom_range(0, 9) == 0);
      buf_switch_in  = ($urandom_range(0, 19) == 0);
      buf_switch_out = ($urandom_range(0, 19) == 0);
      core_ready     = ($urandom_range(0, 3) != 0);
      core_valid     = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : d2;
      @(negedge clk);
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random k=%0d got=%b want=%b", k, act_vec, exp_vec);
      end
      d2 = d1; d1 = rd_en;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ready_toggle();
    test_banks();
    test_protocol();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Stage-side counterpart of the pipeline event system: consumes the `stage_ready` pulse and the buffer-switch pulses of one pipeline stage, and sweeps one frame from the input ping-pong buffer through the stage's processing core into the output ping-pong buffer. It tracks the bank select of both buffers, generates read/write addresses and enables, and returns a single-cycle `stage_done` pulse when the last result word has been written. One instance sits beside each processing stage.

## Interface
- `ADDR_WIDTH`, 10, buffer address width.
- `FRAME_LEN`, 1024, words per frame; legal range 1..2^ADDR_WIDTH.
- `INIT_BANK`, 0, reset value of both bank selects.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stage_ready`  in  1  one-cycle pulse: start one frame.
- `buf_switch_in`  in  1  one-cycle pulse: toggle input-buffer bank.
- `buf_switch_out`  in  1  one-cycle pulse: toggle output-buffer bank.
- `core_ready`  in  1  core accepts a read word this cycle.
- `core_valid`  in  1  core presents a result word this cycle.
- `rd_bank`  out  1  input-buffer bank being read.
- `wr_bank`  out  1  output-buffer bank being written.
- `rd_en`  out  1  read strobe to input buffer / core.
- `rd_addr`  out  ADDR_WIDTH  read address.
- `wr_en`  out  1  write strobe to output buffer.
- `wr_addr`  out  ADDR_WIDTH  write address.
- `busy`  out  1  high in READ, DRAIN, DONE.
- `stage_done`  out  1  one-cycle pulse: frame complete.
- `protocol_err`  out  1  sticky error flag.

## Operation
- States: IDLE, READ, DRAIN, DONE. Reset → IDLE.
- Counters `rd_cnt`, `wr_cnt`, ADDR_WIDTH+1 bits; `rd_addr`/`wr_addr` are their low ADDR_WIDTH bits.
- IDLE: on `stage_ready` → READ; clear `rd_cnt`, `wr_cnt`.
- READ: `rd_en = core_ready` (combinational); each `rd_en` increments `rd_cnt`. When the FRAME_LEN-th read is issued → DRAIN.
- `wr_en = core_valid & busy & (wr_cnt < rd_cnt)` in READ/DRAIN; each `wr_en` increments `wr_cnt`.
- When the FRAME_LEN-th write occurs (in READ or DRAIN) → DONE. Last read and last write in same cycle: READ → DONE directly.
- DONE: `stage_done` = 1 for exactly this cycle, then → IDLE.
- `rd_en` and `wr_en` are 0 in IDLE and DONE.
- Banks: `rd_bank` toggles on `buf_switch_in`, `wr_bank` toggles on `buf_switch_out`, in any state, effective next cycle. Switch pulse in the same cycle as `stage_ready`: new bank is used by the frame.
- `protocol_err` set (sticky until reset) on: `stage_ready` while `busy` (pulse ignored); `buf_switch_in`/`buf_switch_out` while `busy` (toggle still applied); `core_valid` while IDLE/DONE or with `wr_cnt == rd_cnt` (word dropped, no write).

## Timing
- Reset values: state IDLE, `rd_bank = wr_bank = INIT_BANK`, all counters/addresses 0, `rd_en`, `wr_en`, `busy`, `stage_done`, `protocol_err` 0.
- `stage_ready` at cycle N → `busy` and first possible `rd_en` at N+1 (addr 0).
- Core with `core_ready` held 1 and result at fixed latency L: reads N+1..N+FRAME_LEN, last write N+FRAME_LEN+L, `stage_done` one cycle later; earliest next `stage_ready` accepted is the cycle after `stage_done`.
- `rd_addr`/`wr_addr` registered; address presented in the same cycle as its strobe, incremented the cycle after.
- FRAME_LEN = 2^ADDR_WIDTH: addresses wrap to 0 after the last word; completion decided by the extra counter bit, not by address.
- `rst_n` asserted mid-frame: immediate return to reset values; no `stage_done`.

## Test plan
- FRAME_LEN=8, `core_ready`=1, `core_valid` = `rd_en` delayed 2 cycles, `stage_ready` at cycle 10 → `rd_en` cycles 11–18 addr 0–7, `wr_en` 13–20 addr 0–7, `stage_done` only at 21, `protocol_err` 0.
- Same, `core_ready` toggling 1/0 → exactly 8 reads, addresses contiguous, `stage_done` one cycle after 8th write.
- `buf_switch_in` + `buf_switch_out` pulses at cycle 9, `stage_ready` at 10 → `rd_bank = wr_bank = 1` for the whole frame; second frame after two more pulses back at 0.
- `stage_ready` at cycle 14 mid-frame, stray `core_valid` in IDLE → `protocol_err` 1 and stays 1; frame timing unchanged, no extra writes.
- ADDR_WIDTH=3, FRAME_LEN=8 → `wr_addr` 7 then back to 0; `stage_done` exactly once.
- `rst_n` low at cycle 15 mid-frame → outputs at reset values asynchronously; no `stage_done`; next `stage_ready` starts at addr 0.
